// File: rtl/i2c_bus_monitor.sv
// Passive I2C observer: sync/filter SCL/SDA, detect S/Sr/P,
// deserialise bytes + ACK onto a valid/ready output slot.
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       en_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       start_o,
  output logic       rstart_o,
  output logic       stop_o,
  output logic       trunc_o,
  output logic       busy_o,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       ack_o,
  output logic       first_o,
  input  logic       byte_ready_i,
  output logic       overrun_o,
  input  logic       clr_ovr_i
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  logic [1:0]             pins;
  logic [SYNC_STAGES-1:0] sync [2];
  logic [CW-1:0]          cnt  [2];
  logic [1:0]             s;
  logic [1:0]             f;
  logic [1:0]             p;

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       first_q;
  logic       pend;

  logic start_c;
  logic stop_c;
  logic scl_rise;
  logic scl_fall;
  logic byte_done;
  logic partial;

  assign pins = {sda_i, scl_i};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      s[i] = sync[i][SYNC_STAGES-1];
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < 2; i++) begin
        sync[i] <= '1;
        cnt[i]  <= '0;
      end
      f <= '1;
      p <= '1;
    end else begin
      p <= f;
      for (int i = 0; i < 2; i++) begin
        sync[i] <= {sync[i][SYNC_STAGES-2:0], pins[i]};
        if (s[i] == f[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(FILTER_LEN - 1)) begin
          f[i]   <= s[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // index 0 = SCL, 1 = SDA
  assign start_c  = p[1] & ~f[1] & p[0] & f[0];
  assign stop_c   = ~p[1] & f[1] & p[0] & f[0];
  assign scl_rise = ~p[0] & f[0];
  assign scl_fall = p[0] & ~f[0];

  assign byte_done = en_i && (state == RECV) &&
                     scl_rise && (bit_cnt == 4'd8);

  // The SCL high phase carrying an Sr/P is not a data bit.
  assign partial = (bit_cnt != {3'b000, pend});

  always_ff @(posedge pclk) begin
    if (preset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      first_q      <= 1'b0;
      pend         <= 1'b0;
      start_o      <= 1'b0;
      rstart_o     <= 1'b0;
      stop_o       <= 1'b0;
      trunc_o      <= 1'b0;
      busy_o       <= 1'b0;
      byte_valid_o <= 1'b0;
      byte_o       <= '0;
      ack_o        <= 1'b0;
      first_o      <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      start_o  <= 1'b0;
      rstart_o <= 1'b0;
      stop_o   <= 1'b0;
      trunc_o  <= 1'b0;

      if (!en_i) begin
        state   <= IDLE;
        busy_o  <= 1'b0;
        bit_cnt <= '0;
        pend    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start_c) begin
              state   <= RECV;
              start_o <= 1'b1;
              busy_o  <= 1'b1;
              bit_cnt <= '0;
              pend    <= 1'b0;
              first_q <= 1'b1;
            end
          end
          RECV: begin
            unique case (1'b1)
              start_c: begin
                rstart_o <= 1'b1;
                trunc_o  <= partial;
                bit_cnt  <= '0;
                shreg    <= '0;
                pend     <= 1'b0;
                first_q  <= 1'b1;
              end
              stop_c: begin
                stop_o  <= 1'b1;
                trunc_o <= partial;
                busy_o  <= 1'b0;
                bit_cnt <= '0;
                pend    <= 1'b0;
                state   <= IDLE;
              end
              scl_rise: begin
                if (bit_cnt == 4'd8) begin
                  bit_cnt <= '0;
                  first_q <= 1'b0;
                end else begin
                  shreg   <= {shreg[6:0], f[1]};
                  bit_cnt <= bit_cnt + 4'd1;
                  pend    <= 1'b1;
                end
              end
              scl_fall: pend <= 1'b0;
              default: ;
            endcase
          end
          default: state <= IDLE;
        endcase
      end

      if (byte_valid_o && byte_ready_i) begin
        byte_valid_o <= 1'b0;
      end
      if (clr_ovr_i) begin
        overrun_o <= 1'b0;
      end
      if (byte_done) begin
        if (!byte_valid_o || byte_ready_i) begin
          byte_o       <= shreg;
          ack_o        <= ~f[1];
          first_o      <= first_q;
          byte_valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor: bit-banged bus,
// byte scoreboard and event counters.
module tb_i2c_bus_monitor;

  localparam int Q  = 8;
  localparam int FL = 3;

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic       en_i = 1'b1;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic       start_o;
  logic       rstart_o;
  logic       stop_o;
  logic       trunc_o;
  logic       busy_o;
  logic       byte_valid_o;
  logic [7:0] byte_o;
  logic       ack_o;
  logic       first_o;
  logic       byte_ready_i = 1'b1;
  logic       overrun_o;
  logic       clr_ovr_i = 1'b0;

  int tests = 0;
  int failed = 0;
  int n_start = 0;
  int n_rstart = 0;
  int n_stop = 0;
  int n_trunc = 0;
  int n_trunc_stop = 0;
  int n_bytes = 0;
  logic [9:0] sb [$];

  i2c_bus_monitor #(.SYNC_STAGES(2), .FILTER_LEN(FL)) dut (
    .pclk(pclk),
    .preset(preset),
    .en_i(en_i),
    .scl_i(scl),
    .sda_i(sda),
    .start_o(start_o),
    .rstart_o(rstart_o),
    .stop_o(stop_o),
    .trunc_o(trunc_o),
    .busy_o(busy_o),
    .byte_valid_o(byte_valid_o),
    .byte_o(byte_o),
    .ack_o(ack_o),
    .first_o(first_o),
    .byte_ready_i(byte_ready_i),
    .overrun_o(overrun_o),
    .clr_ovr_i(clr_ovr_i)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] mk(input logic [7:0] b,
                                    input logic a,
                                    input logic fst);
    return {fst, a, b};
  endfunction

  always @(negedge pclk) begin
    #1;
    if (!preset) begin
      if (start_o) n_start++;
      if (rstart_o) n_rstart++;
      if (stop_o) n_stop++;
      if (trunc_o) begin
        n_trunc++;
        if (stop_o) n_trunc_stop++;
      end
      if (byte_valid_o && byte_ready_i) begin
        n_bytes++;
        if (sb.size() == 0) begin
          check("unexpected_byte", {22'd0, first_o, ack_o, byte_o}, 32'h3ff);
        end else begin
          check("byte", {22'd0, first_o, ack_o, byte_o},
                {22'd0, sb.pop_front()});
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic bus_start();
    sda = 1'b1; cyc(Q);
    scl = 1'b1; cyc(Q);
    sda = 1'b0; cyc(Q);
    scl = 1'b0; cyc(Q);
  endtask

  task automatic bus_stop();
    sda = 1'b0; cyc(Q);
    scl = 1'b1; cyc(Q);
    sda = 1'b1; cyc(2 * Q);
  endtask

  task automatic send_bit(input logic b);
    sda = b;    cyc(Q);
    scl = 1'b1; cyc(2 * Q);
    scl = 1'b0; cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic a);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(~a);
  endtask

  initial begin
    int s0;
    int b0;

    cyc(4);
    preset = 1'b0;
    cyc(2 * Q);
    check("reset_outputs",
          {15'd0, start_o, rstart_o, stop_o, trunc_o, busy_o,
           byte_valid_o, ack_o, first_o, overrun_o, byte_o}, 32'd0);
    check("reset_no_start", n_start, 0);

    // Two bytes, ACK then NACK
    bus_start();
    check("t1_start", n_start, 1);
    check("t1_busy", busy_o, 1);
    sb.push_back(mk(8'hA0, 1'b1, 1'b1));
    send_byte(8'hA0, 1'b1);
    sb.push_back(mk(8'h5A, 1'b0, 1'b0));
    send_byte(8'h5A, 1'b0);
    bus_stop();
    check("t1_stop", n_stop, 1);
    check("t1_busy_after", busy_o, 0);
    check("t1_bytes", n_bytes, 2);
    check("t1_trunc", n_trunc, 0);

    // Repeated START
    bus_start();
    sb.push_back(mk(8'h90, 1'b1, 1'b1));
    send_byte(8'h90, 1'b1);
    bus_start();
    check("t2_rstart", n_rstart, 1);
    check("t2_busy", busy_o, 1);
    sb.push_back(mk(8'h91, 1'b1, 1'b1));
    send_byte(8'h91, 1'b1);
    bus_stop();
    check("t2_start", n_start, 2);
    check("t2_stop", n_stop, 2);
    check("t2_trunc", n_trunc, 0);
    check("t2_bytes", n_bytes, 4);

    // Partial byte aborted by STOP
    bus_start();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    bus_stop();
    check("t3_trunc", n_trunc, 1);
    check("t3_trunc_with_stop", n_trunc_stop, 1);
    check("t3_stop", n_stop, 3);
    check("t3_no_byte", n_bytes, 4);

    // SDA glitches while idle
    s0 = n_start;
    sda = 1'b0; cyc(FL - 1);
    sda = 1'b1; cyc(3 * Q);
    check("t4_short_glitch", n_start, s0);
    sda = 1'b0; cyc(FL);
    sda = 1'b1; cyc(3 * Q);
    check("t4_long_glitch", n_start, s0 + 1);
    check("t4_glitch_stop", n_stop, 4);
    check("t4_idle", busy_o, 0);

    // Overrun with stalled consumer
    byte_ready_i = 1'b0;
    bus_start();
    sb.push_back(mk(8'h11, 1'b1, 1'b1));
    send_byte(8'h11, 1'b1);
    check("t5_valid", byte_valid_o, 1);
    check("t5_no_ovr_yet", overrun_o, 0);
    send_byte(8'h22, 1'b1);
    bus_stop();
    check("t5_held_byte", byte_o, 8'h11);
    check("t5_overrun", overrun_o, 1);
    byte_ready_i = 1'b1;
    cyc(4);
    check("t5_drained", byte_valid_o, 0);
    check("t5_ovr_sticky", overrun_o, 1);
    clr_ovr_i = 1'b1; cyc(1);
    clr_ovr_i = 1'b0; cyc(2);
    check("t5_ovr_clear", overrun_o, 0);

    // Monitor disabled
    en_i = 1'b0;
    s0 = n_start;
    b0 = n_bytes;
    bus_start();
    send_byte(8'h33, 1'b1);
    bus_stop();
    check("t6_dis_start", n_start, s0);
    check("t6_dis_bytes", n_bytes, b0);
    check("t6_dis_busy", busy_o, 0);
    en_i = 1'b1;
    cyc(Q);

    // Reset in the middle of a byte
    bus_start();
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    s0 = n_start;
    preset = 1'b1;
    scl = 1'b1;
    sda = 1'b1;
    cyc(5);
    preset = 1'b0;
    cyc(3 * Q);
    check("t7_outputs",
          {15'd0, start_o, rstart_o, stop_o, trunc_o, busy_o,
           byte_valid_o, ack_o, first_o, overrun_o, byte_o}, 32'd0);
    check("t7_no_false_start", n_start, s0);
    bus_start();
    check("t7_start", n_start, s0 + 1);
    sb.push_back(mk(8'h3C, 1'b1, 1'b1));
    send_byte(8'h3C, 1'b1);
    bus_stop();
    check("t7_busy_after", busy_o, 0);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
